// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FP op codes, default latencies and helpers
package fpu_pkg;

    localparam logic [3:0] FOP_ADD     = 4'd0;
    localparam logic [3:0] FOP_SUB     = 4'd1;
    localparam logic [3:0] FOP_MUL     = 4'd2;
    localparam logic [3:0] FOP_DIV     = 4'd3;
    localparam logic [3:0] FOP_SQRT    = 4'd4;
    localparam logic [3:0] FOP_FTOI    = 4'd5;
    localparam logic [3:0] FOP_FEQ     = 4'd6;
    localparam logic [3:0] FOP_FLT     = 4'd7;
    localparam logic [3:0] FOP_FLE     = 4'd8;
    localparam logic [3:0] FOP_ITOF    = 4'd9;
    localparam logic [3:0] FOP_ILL_MIN = 4'd10;

    localparam int DEF_LAT_ADDSUB = 2;
    localparam int DEF_LAT_MUL    = 2;
    localparam int DEF_LAT_DIV    = 10;
    localparam int DEF_LAT_SQRT   = 10;
    localparam int DEF_LAT_CVT    = 1;
    localparam int DEF_LAT_CMP    = 1;
    localparam int DEF_CNT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } fpu_state_e;

    // FTOI and the compares write the integer register file
    function automatic logic is_int_dest(input logic [3:0] op);
        return (op == FOP_FTOI) || (op == FOP_FEQ) || (op == FOP_FLT) || (op == FOP_FLE);
    endfunction

endpackage

// File: rtl/fpu_lat_lut.sv
// rtl/fpu_lat_lut.sv - op code to FPU result latency lookup
module fpu_lat_lut
    import fpu_pkg::*;
#(
    parameter int LAT_ADDSUB = DEF_LAT_ADDSUB,
    parameter int LAT_MUL    = DEF_LAT_MUL,
    parameter int LAT_DIV    = DEF_LAT_DIV,
    parameter int LAT_SQRT   = DEF_LAT_SQRT,
    parameter int LAT_CVT    = DEF_LAT_CVT,
    parameter int LAT_CMP    = DEF_LAT_CMP,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic [3:0]       i_op,
    output logic [CNT_W-1:0] o_lat
);

    // undefined codes run with the conversion latency
    always_comb begin
        o_lat = CNT_W'(LAT_CVT);
        case (i_op)
            FOP_ADD, FOP_SUB:          o_lat = CNT_W'(LAT_ADDSUB);
            FOP_MUL:                   o_lat = CNT_W'(LAT_MUL);
            FOP_DIV:                   o_lat = CNT_W'(LAT_DIV);
            FOP_SQRT:                  o_lat = CNT_W'(LAT_SQRT);
            FOP_FTOI, FOP_ITOF:        o_lat = CNT_W'(LAT_CVT);
            FOP_FEQ, FOP_FLT, FOP_FLE: o_lat = CNT_W'(LAT_CMP);
            default:                   o_lat = CNT_W'(LAT_CVT);
        endcase
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// rtl/fpu_issue_ctrl.sv - single-op issue sequencer for the shared multi-cycle FPU
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int LAT_ADDSUB = DEF_LAT_ADDSUB,
    parameter int LAT_MUL    = DEF_LAT_MUL,
    parameter int LAT_DIV    = DEF_LAT_DIV,
    parameter int LAT_SQRT   = DEF_LAT_SQRT,
    parameter int LAT_CVT    = DEF_LAT_CVT,
    parameter int LAT_CMP    = DEF_LAT_CMP,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [3:0]  issue_op,
    input  logic [4:0]  issue_rd,
    input  logic        flush,
    output logic        fpu_start,
    output logic [3:0]  fpu_op,
    input  logic [31:0] fpu_result,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_is_int,
    output logic        illegal,
    output logic        stall
);

    fpu_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_op;
    logic [4:0]       r_rd;
    logic             r_fpu_start;
    logic             r_illegal;
    logic             r_wb_valid;
    logic [31:0]      r_wb_data;
    logic [4:0]       r_wb_rd;
    logic             r_wb_is_int;

    logic [CNT_W-1:0] w_lat;
    logic             w_accept;

    fpu_lat_lut #(
        .LAT_ADDSUB (LAT_ADDSUB),
        .LAT_MUL    (LAT_MUL),
        .LAT_DIV    (LAT_DIV),
        .LAT_SQRT   (LAT_SQRT),
        .LAT_CVT    (LAT_CVT),
        .LAT_CMP    (LAT_CMP),
        .CNT_W      (CNT_W)
    ) u_lat_lut (
        .i_op  (issue_op),
        .o_lat (w_lat)
    );

    // WB with wb_ready frees the slot in the same cycle for back-to-back issue
    assign issue_ready = ~flush & ((r_state == ST_IDLE) | ((r_state == ST_WB) & wb_ready));
    assign w_accept    = issue_valid & issue_ready;
    assign stall       = issue_valid & ~issue_ready;

    assign fpu_start = r_fpu_start;
    assign fpu_op    = r_op;
    assign illegal   = r_illegal;
    assign wb_valid  = r_wb_valid;
    assign wb_data   = r_wb_data;
    assign wb_rd     = r_wb_rd;
    assign wb_is_int = r_wb_is_int;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_op        <= '0;
            r_rd        <= '0;
            r_fpu_start <= 1'b0;
            r_illegal   <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_wb_data   <= '0;
            r_wb_rd     <= '0;
            r_wb_is_int <= 1'b0;
        end else if (flush) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_fpu_start <= 1'b0;
            r_illegal   <= 1'b0;
            r_wb_valid  <= 1'b0;
        end else begin
            r_fpu_start <= 1'b0;
            r_illegal   <= 1'b0;
            if (w_accept) begin
                r_state     <= ST_EXEC;
                r_op        <= issue_op;
                r_rd        <= issue_rd;
                r_cnt       <= w_lat;
                r_fpu_start <= 1'b1;
                r_illegal   <= (issue_op >= FOP_ILL_MIN);
                r_wb_valid  <= 1'b0;
            end else begin
                case (r_state)
                    ST_EXEC: begin
                        if (r_cnt == '0) begin
                            r_wb_data   <= fpu_result;
                            r_wb_rd     <= r_rd;
                            r_wb_is_int <= is_int_dest(r_op);
                            r_wb_valid  <= 1'b1;
                            r_state     <= ST_WB;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    ST_WB: begin
                        if (wb_ready) begin
                            r_wb_valid <= 1'b0;
                            r_state    <= ST_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb/tb_fpu_issue_ctrl.sv - directed and random checks of fpu_issue_ctrl against a timestamp model
module tb_fpu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        issue_valid;
    logic        issue_ready;
    logic [3:0]  issue_op;
    logic [4:0]  issue_rd;
    logic        flush;
    logic        fpu_start;
    logic [3:0]  fpu_op;
    logic [31:0] fpu_result;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_is_int;
    logic        illegal;
    logic        stall;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // model: an op in flight is described by the cycle in which its result is sampled
    int          lat_tab [16] = '{2, 2, 2, 10, 10, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    bit          m_inflight;
    int          m_cap_cyc;
    bit          m_wbv;
    bit          m_start;
    bit          m_ill;
    logic [3:0]  m_op;
    logic [4:0]  m_pend_rd;
    logic [31:0] m_data;
    logic [4:0]  m_rd;
    bit          m_isint;
    int          n_wb_seen;

    always #5 clk = ~clk;

    fpu_issue_ctrl dut (
        .clk         (clk),
        .rstn        (rstn),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_op    (issue_op),
        .issue_rd    (issue_rd),
        .flush       (flush),
        .fpu_start   (fpu_start),
        .fpu_op      (fpu_op),
        .fpu_result  (fpu_result),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_data     (wb_data),
        .wb_rd       (wb_rd),
        .wb_is_int   (wb_is_int),
        .illegal     (illegal),
        .stall       (stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_inflight = 0; m_cap_cyc = 0; m_wbv = 0; m_start = 0; m_ill = 0;
        m_op = '0; m_pend_rd = '0; m_data = '0; m_rd = '0; m_isint = 0;
    endtask

    // one clock cycle: drive, check at negedge, advance model, cross posedge
    task automatic step(input bit rs, input bit iv, input logic [3:0] op, input logic [4:0] rd,
                        input bit fl, input bit wr);
        bit exp_ready;
        bit acc;
        rstn = rs; issue_valid = iv; issue_op = op; issue_rd = rd; flush = fl; wb_ready = wr;
        fpu_result = $urandom;
        @(negedge clk);
        exp_ready = !fl && !m_inflight && (!m_wbv || wr);
        chk("issue_ready", 32'(issue_ready), 32'(exp_ready));
        chk("stall",       32'(stall),       32'(iv && !exp_ready));
        chk("fpu_start",   32'(fpu_start),   32'(m_start));
        chk("fpu_op",      32'(fpu_op),      32'(m_op));
        chk("illegal",     32'(illegal),     32'(m_ill));
        chk("wb_valid",    32'(wb_valid),    32'(m_wbv));
        chk("wb_data",     wb_data,          m_data);
        chk("wb_rd",       32'(wb_rd),       32'(m_rd));
        chk("wb_is_int",   32'(wb_is_int),   32'(m_isint));
        if (m_wbv && wr) n_wb_seen++;
        if (!rs) begin
            model_reset();
        end else if (fl) begin
            m_inflight = 0; m_wbv = 0; m_start = 0; m_ill = 0;
        end else begin
            acc = iv && exp_ready;
            m_start = acc;
            m_ill = acc && (op >= 4'd10);
            if (m_wbv && wr) begin
                m_wbv = 0;
            end else if (m_inflight && cyc == m_cap_cyc) begin
                m_data = fpu_result; m_rd = m_pend_rd;
                m_isint = (op_int(m_op));
                m_inflight = 0; m_wbv = 1;
            end
            if (acc) begin
                m_inflight = 1; m_op = op; m_pend_rd = rd;
                m_cap_cyc = cyc + 1 + lat_tab[op];
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic bit op_int(input logic [3:0] op);
        return (op >= 4'd5) && (op <= 4'd8);
    endfunction

    task automatic idle(input int n, input bit wr);
        for (int i = 0; i < n; i++) step(1, 0, 4'd0, 5'd0, 0, wr);
    endtask

    initial begin
        rstn = 0; issue_valid = 0; issue_op = 0; issue_rd = 0; flush = 0; wb_ready = 0;
        fpu_result = 0;
        model_reset();
        n_wb_seen = 0;
        @(posedge clk);
        #1;
        step(0, 0, 4'd0, 5'd0, 0, 0);
        idle(1, 0);
        // FADD, result held until writeback accepts
        step(1, 1, 4'd0, 5'd3, 0, 0);
        idle(6, 0);
        idle(1, 1);
        // FDIV stalled in WB, FEQ issued back-to-back on wb_ready
        step(1, 1, 4'd3, 5'd17, 0, 0);
        for (int i = 0; i < 17; i++) step(1, 1, 4'd6, 5'd9, 0, 0);
        step(1, 1, 4'd6, 5'd9, 0, 1);
        idle(4, 0);
        chk("feq_wb_is_int", 32'(wb_is_int), 32'd1);
        idle(1, 1);
        // FSQRT flushed in its 4th EXEC cycle
        step(1, 1, 4'd4, 5'd21, 0, 1);
        idle(3, 1);
        step(1, 0, 4'd0, 5'd0, 1, 1);
        idle(12, 1);
        // flush together with issue_valid
        step(1, 1, 4'd2, 5'd5, 1, 1);
        idle(2, 1);
        // undefined op code
        step(1, 1, 4'hf, 5'd30, 0, 0);
        idle(5, 0);
        // reset while in WB
        step(0, 0, 4'd0, 5'd0, 0, 0);
        idle(2, 1);
        // random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 59) != 0), $urandom_range(0, 1),
                 4'($urandom_range(0, 15)), 5'($urandom), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 2) != 0));
        end
        n_tests++;
        assert (n_wb_seen > 10) else begin
            n_fail++;
            $error("FAIL wb_count: observed %0d expected >10", n_wb_seen);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
